// File: rtl/compound_in_receiver.sv
// Receiver for the blocking sync/notify CompoundType port: buffers accepted words
// in a small first-word-fall-through FIFO and presents the head with valid/ack.
//  state | meaning
//  IDLE  | first cycle after reset release, no transfers
//  RUN   | normal push/pop operation
//  FLUSH | single cycle clearing all buffered words
module compound_in_receiver #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_in_sync,
    output logic              b_in_notify,
    input  logic              flush,
    output logic [DATA_W-1:0] m_out,
    output logic              m_out_valid,
    input  logic              m_out_ack,
    output logic [CNT_W-1:0]  rx_count,
    output logic [1:0]        section_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rx_q, rx_d;
    logic              notify_q, notify_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push, pop;

    // flush takes priority: neither side transfers in the cycle it is seen
    assign push = (state_q == RUN) && !flush && b_in_sync && notify_q;
    assign pop  = (state_q == RUN) && !flush && m_out_ack && (count_q != '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rx_d     = rx_q;
        unique case (state_q)
            IDLE:  state_d = RUN;
            RUN: begin
                if (flush) state_d = FLUSH;
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rx_d     = rx_q + CNT_W'(1);
                end
                if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
                if (push && !pop)      count_d = count_q + CW'(1);
                else if (pop && !push) count_d = count_q - CW'(1);
            end
            FLUSH: begin
                state_d  = RUN;
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
            end
            default: state_d = IDLE;
        endcase
        notify_d = (state_d == RUN) && (count_d < FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rx_q     <= '0;
            notify_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rx_q     <= rx_d;
            notify_q <= notify_d;
        end
    end

    // storage is deliberately left unreset; valid gating hides stale contents
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= b_in;
    end

    assign b_in_notify = notify_q;
    assign m_out_valid = (count_q != '0);
    assign m_out       = m_out_valid ? mem[rd_ptr_q] : '0;
    assign rx_count    = rx_q;
    assign section_out = state_q;

endmodule

// File: tb/tb_compound_in_receiver.sv
// Directed self-checking bench for compound_in_receiver.
module tb_compound_in_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] b_in;
    logic        b_in_sync;
    logic        b_in_notify;
    logic        flush;
    logic [31:0] m_out;
    logic        m_out_valid;
    logic        m_out_ack;
    logic [15:0] rx_count;
    logic [1:0]  section_out;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_rx = 16'd0;
    logic [31:0] expq [$];

    compound_in_receiver #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync),
        .b_in_notify(b_in_notify), .flush(flush), .m_out(m_out),
        .m_out_valid(m_out_valid), .m_out_ack(m_out_ack),
        .rx_count(rx_count), .section_out(section_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_in = '0; b_in_sync = 1'b0; flush = 1'b0; m_out_ack = 1'b0;
        step(); step();
        n_total++;
        if ({b_in_notify, m_out_valid, section_out} !== 4'b0 || m_out !== 32'd0 || rx_count !== 16'd0)
            $display("FAIL reset_held: notify=%b valid=%b section=%0d m_out=%h rx=%h required all zero",
                     b_in_notify, m_out_valid, section_out, m_out, rx_count);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (b_in_notify !== 1'b0 || section_out !== 2'd0)
            $display("FAIL idle_cycle: notify=%b section=%0d required 0/0", b_in_notify, section_out);
        else n_pass++;
        step();
        n_total++;
        if (b_in_notify !== 1'b1 || section_out !== 2'd1 || m_out_valid !== 1'b0 || m_out !== 32'd0)
            $display("FAIL run_entry: notify=%b section=%0d valid=%b m_out=%h required 1/1/0/0",
                     b_in_notify, section_out, m_out_valid, m_out);
        else n_pass++;
    endtask

    task automatic test_single();
        b_in = 32'hA5A5_0001; b_in_sync = 1'b1;
        step();
        b_in_sync = 1'b0; exp_rx++;
        n_total++;
        if (m_out_valid !== 1'b1 || m_out !== 32'hA5A5_0001 || rx_count !== exp_rx)
            $display("FAIL single_push: valid=%b m_out=%h rx=%h required 1/a5a50001/%h",
                     m_out_valid, m_out, rx_count, exp_rx);
        else n_pass++;
        m_out_ack = 1'b1;
        step();
        m_out_ack = 1'b0;
        n_total++;
        if (m_out_valid !== 1'b0 || m_out !== 32'd0)
            $display("FAIL single_pop: valid=%b m_out=%h required 0/0", m_out_valid, m_out);
        else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 1; i <= 6; i++) begin
            b_in = 32'(i); b_in_sync = 1'b1;
            n_total++;
            if (b_in_notify !== (i <= 4))
                $display("FAIL full_notify[%0d]: notify=%b required %b", i, b_in_notify, (i <= 4));
            else n_pass++;
            step();
        end
        b_in_sync = 1'b0;
        exp_rx += 16'd4;
        n_total++;
        if (rx_count !== exp_rx || m_out !== 32'd1 || b_in_notify !== 1'b0)
            $display("FAIL full_hold: rx=%h m_out=%h notify=%b required %h/1/0",
                     rx_count, m_out, b_in_notify, exp_rx);
        else n_pass++;
        m_out_ack = 1'b1;
        step();
        m_out_ack = 1'b0;
        n_total++;
        if (b_in_notify !== 1'b1 || m_out !== 32'd2)
            $display("FAIL full_pop_bubble: notify=%b m_out=%h required 1/2", b_in_notify, m_out);
        else n_pass++;
        b_in = 32'd5; b_in_sync = 1'b1;
        step();
        b_in_sync = 1'b0; exp_rx++;
        n_total++;
        if (rx_count !== exp_rx || b_in_notify !== 1'b0)
            $display("FAIL full_refill: rx=%h notify=%b required %h/0", rx_count, b_in_notify, exp_rx);
        else n_pass++;
        for (int i = 2; i <= 5; i++) begin
            n_total++;
            if (m_out_valid !== 1'b1 || m_out !== 32'(i))
                $display("FAIL full_drain[%0d]: valid=%b m_out=%h required 1/%h", i, m_out_valid, m_out, 32'(i));
            else n_pass++;
            m_out_ack = 1'b1;
            step();
            m_out_ack = 1'b0;
        end
        n_total++;
        if (m_out_valid !== 1'b0)
            $display("FAIL full_empty: valid=%b required 0", m_out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        expq.delete();
        for (int i = 0; i < 3; i++) begin
            b_in = 32'h10 + 32'(i); b_in_sync = 1'b1;
            expq.push_back(b_in);
            step();
            exp_rx++;
        end
        for (int i = 3; i < 13; i++) begin
            b_in = 32'h10 + 32'(i); b_in_sync = 1'b1; m_out_ack = 1'b1;
            n_total++;
            if (m_out !== expq[0] || b_in_notify !== 1'b1)
                $display("FAIL b2b_head[%0d]: m_out=%h notify=%b required %h/1", i, m_out, b_in_notify, expq[0]);
            else n_pass++;
            void'(expq.pop_front());
            expq.push_back(b_in);
            step();
            exp_rx++;
        end
        b_in_sync = 1'b0; m_out_ack = 1'b0;
        n_total++;
        if (rx_count !== exp_rx || m_out_valid !== 1'b1)
            $display("FAIL b2b_count: rx=%h valid=%b required %h/1", rx_count, m_out_valid, exp_rx);
        else n_pass++;
        while (expq.size() != 0) begin
            n_total++;
            if (m_out !== expq[0])
                $display("FAIL b2b_drain: m_out=%h required %h", m_out, expq[0]);
            else n_pass++;
            void'(expq.pop_front());
            m_out_ack = 1'b1;
            step();
            m_out_ack = 1'b0;
        end
        n_total++;
        if (m_out_valid !== 1'b0 || m_out !== 32'd0)
            $display("FAIL b2b_empty: valid=%b m_out=%h required 0/0", m_out_valid, m_out);
        else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            b_in = 32'h20 + 32'(i); b_in_sync = 1'b1;
            step();
            exp_rx++;
        end
        b_in = 32'h99; b_in_sync = 1'b1; m_out_ack = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; b_in_sync = 1'b0; m_out_ack = 1'b0;
        n_total++;
        if (section_out !== 2'd2 || b_in_notify !== 1'b0 || rx_count !== exp_rx || m_out !== 32'h20)
            $display("FAIL flush_state: section=%0d notify=%b rx=%h m_out=%h required 2/0/%h/20",
                     section_out, b_in_notify, rx_count, m_out, exp_rx);
        else n_pass++;
        b_in_sync = 1'b1; b_in = 32'h77;
        step();
        b_in_sync = 1'b0;
        n_total++;
        if (section_out !== 2'd1 || m_out_valid !== 1'b0 || m_out !== 32'd0 ||
            rx_count !== exp_rx || b_in_notify !== 1'b1)
            $display("FAIL flush_done: section=%0d valid=%b m_out=%h rx=%h notify=%b required 1/0/0/%h/1",
                     section_out, m_out_valid, m_out, rx_count, b_in_notify, exp_rx);
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        int n;
        n = 32'hFFFF - int'(exp_rx);
        b_in_sync = 1'b1; m_out_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            b_in = 32'(i);
            step();
        end
        exp_rx = 16'hFFFF;
        n_total++;
        if (rx_count !== exp_rx)
            $display("FAIL rx_max: rx=%h required ffff", rx_count);
        else n_pass++;
        b_in = 32'hCAFE_0000;
        step();
        n_total++;
        if (rx_count !== 16'h0000)
            $display("FAIL rx_wrap: rx=%h required 0000", rx_count);
        else n_pass++;
        m_out_ack = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({b_in_notify, m_out_valid, section_out} !== 4'b0 || m_out !== 32'd0 || rx_count !== 16'd0)
            $display("FAIL async_reset: notify=%b valid=%b section=%0d m_out=%h rx=%h required all zero",
                     b_in_notify, m_out_valid, section_out, m_out, rx_count);
        else n_pass++;
        b_in_sync = 1'b0;
        step();
        rst = 1'b0;
        step();
        n_total++;
        if (section_out !== 2'd1 || m_out_valid !== 1'b0 || rx_count !== 16'd0)
            $display("FAIL reset_recover: section=%0d valid=%b rx=%h required 1/0/0",
                     section_out, m_out_valid, rx_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
